watchdog_multi: RTL and testbench

//  Multi-channel windowed watchdog on the IO bus. NCH independent channels share one prescaled tick.

---
 rtl/watchdog_multi.sv | 213 +++++++++++++++++++++
 tb/tb_watchdog_multi.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watchdog_multi.sv
// -----------------------------------------------------------------------------
// watchdog_multi
//   Multi-channel windowed watchdog on a simple zero-wait IO bus.
//   NCH independent channels share one prescaled tick ("ctick"). Each channel
//   has a late-timeout limit (ticker reaches timeout) and an optional early
//   window (a kick arriving while ticker < window is a violation). A
//   violation is sticky in trig[n] until the channel is cleared or
//   reprogrammed. trig_any is the OR of all channels.
//
// Parameters
//   NCH   number of channels, 1..16
//   CW    ticker/timeout/window width, 1..16 (read fields zero-extended to 16)
//   PRESC input tick pulses per channel tick, 1..256
//
// Ports
//   clk       in   1        system clock
//   rst       in   1        asynchronous, active-high reset
//   tick      in   1        1-cycle time base pulse
//   stb       in   1        bus strobe
//   we        in   1        1 = write, 0 = read
//   addr      in   AW       AW = clog2(NCH)+1; [0] field select, [AW-1:1] channel
//   data_in   in   32       write data; [31:30] = opcode, [CW-1:0] = value
//   data_out  out  32       read data, combinational; 0 when not reading
//   trig      out  NCH      per-channel sticky violation (early | late)
//   trig_any  out  1        OR of trig
//   ack       out  1        equals stb (zero-wait bus)
//
// Write opcodes (data_in[31:30])
//   00 SETTO  load timeout, restart ticker, clear flags, arm if value != 0
//   01 SETWIN load window, window mode on if value != 0
//   10 KICK   armed only: early violation if inside window, else restart ticker
//   11 CLEAR  clear flags, restart ticker, re-arm if timeout != 0
//
// Read map (channel < NCH, otherwise 0)
//   addr[0]=0 : {ticker, timeout}
//   addr[0]=1 : {window, 12'b0, wmode, enable, early, late}
// -----------------------------------------------------------------------------
module watchdog_multi #(
   parameter int NCH   = 4,
   parameter int CW    = 16,
   parameter int PRESC = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  stb,
   input  logic                  we,
   input  logic [$clog2(NCH):0]  addr,
   input  logic [31:0]           data_in,
   output logic [31:0]           data_out,
   output logic [NCH-1:0]        trig,
   output logic                  trig_any,
   output logic                  ack
);

   localparam int AW  = $clog2(NCH) + 1;
   // A single-channel build has no channel field in addr; keep a 1-bit
   // channel index tied to zero so the decode below stays uniform.
   localparam int CHW = (AW > 1) ? AW - 1 : 1;
   localparam int PW  = (PRESC > 1) ? $clog2(PRESC) : 1;

   typedef enum logic [1:0] {
      OP_SETTO  = 2'b00,
      OP_SETWIN = 2'b01,
      OP_KICK   = 2'b10,
      OP_CLEAR  = 2'b11
   } op_e;

   // ---------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------
   logic [CHW-1:0] w_ch;
   op_e            w_op;
   logic [CW-1:0]  w_val;
   logic           w_wr;
   logic           w_rd;
   logic           w_ctick;
   logic           w_unused;

   generate
      if (AW > 1) begin : g_ch_field
         assign w_ch = addr[AW-1:1];
      end else begin : g_ch_none
         assign w_ch = '0;
      end
   endgenerate

   assign w_op  = op_e'(data_in[31:30]);
   assign w_val = data_in[CW-1:0];
   assign w_wr  = stb & we;
   assign w_rd  = stb & ~we;
   assign ack   = stb;

   // Payload bits between the value field and the opcode carry no meaning.
   assign w_unused = ^data_in[29:CW];

   // ---------------------------------------------------------------------
   // Prescaler: one channel tick per PRESC input tick pulses
   // ---------------------------------------------------------------------
   logic [PW-1:0] r_pcnt;

   assign w_ctick = tick & (r_pcnt == PW'(PRESC - 1));

   // NOTE: sequential state is assigned with <= so every register samples
   // the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcnt <= '0;
      end else if (tick) begin
         r_pcnt <= w_ctick ? '0 : r_pcnt + PW'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Channel state
   // ---------------------------------------------------------------------
   logic [CW-1:0]  r_timeout [NCH];
   logic [CW-1:0]  r_window  [NCH];
   logic [CW-1:0]  r_ticker  [NCH];
   logic [NCH-1:0] r_enable;
   logic [NCH-1:0] r_wmode;
   logic [NCH-1:0] r_early;
   logic [NCH-1:0] r_late;

   // NOTE: the per-channel arrays are small flop banks, not RAM, and every
   // entry must come out of reset known, so the reset branch loops over all.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            r_timeout[c] <= '0;
            r_window[c]  <= '0;
            r_ticker[c]  <= '0;
         end
         r_enable <= '0;
         r_wmode  <= '0;
         r_early  <= '0;
         r_late   <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            // A bus write to this channel takes precedence over its timeout
            // check and tick increment in the same cycle. Writes addressed
            // beyond NCH-1 match no channel and are dropped here.
            if (w_wr && (w_ch == CHW'(c))) begin
               unique case (w_op)
                  OP_SETTO: begin
                     r_timeout[c] <= w_val;
                     r_ticker[c]  <= '0;
                     r_early[c]   <= 1'b0;
                     r_late[c]    <= 1'b0;
                     r_enable[c]  <= (w_val != '0);
                  end
                  OP_SETWIN: begin
                     r_window[c] <= w_val;
                     r_wmode[c]  <= (w_val != '0);
                  end
                  OP_KICK: begin
                     if (r_enable[c]) begin
                        if (r_wmode[c] && (r_ticker[c] < r_window[c])) begin
                           // Kick too early: freeze ticker so the read-back
                           // shows where in the window it landed.
                           r_early[c]  <= 1'b1;
                           r_enable[c] <= 1'b0;
                        end else begin
                           r_ticker[c] <= '0;
                        end
                     end
                  end
                  OP_CLEAR: begin
                     r_early[c]  <= 1'b0;
                     r_late[c]   <= 1'b0;
                     r_ticker[c] <= '0;
                     r_enable[c] <= (r_timeout[c] != '0);
                  end
               endcase
            end else if (r_enable[c]) begin
               // Equality is checked every cycle, so ticker never exceeds
               // timeout while armed and cannot wrap.
               if (r_ticker[c] == r_timeout[c]) begin
                  r_late[c]   <= 1'b1;
                  r_enable[c] <= 1'b0;
               end else if (w_ctick) begin
                  r_ticker[c] <= r_ticker[c] + CW'(1);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign trig     = r_early | r_late;
   assign trig_any = |trig;

   // NOTE: data_out gets a default before any conditional assignment so the
   // combinational read mux can never hold a previous value (no latch).
   always_comb begin
      data_out = '0;
      if (w_rd) begin
         for (int c = 0; c < NCH; c++) begin
            if (w_ch == CHW'(c)) begin
               if (addr[0]) begin
                  data_out = {16'(r_window[c]), 12'b0,
                              r_wmode[c], r_enable[c], r_early[c], r_late[c]};
               end else begin
                  data_out = {16'(r_ticker[c]), 16'(r_timeout[c])};
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_watchdog_multi.sv
// -----------------------------------------------------------------------------
// tb_watchdog_multi
//   Two watchdog_multi instances share one bus and tick stream:
//     dut_a : NCH=3, CW=16, PRESC=1
//     dut_b : NCH=3, CW=8,  PRESC=4
//   NCH=3 leaves channel index 3 addressable, so out-of-range accesses can be
//   exercised. A per-channel behavioural model (plain integers) predicts
//   trig and read data; the driver pushes one expectation per cycle into a
//   scoreboard queue and a separate monitor pops and compares on the falling
//   edge. A few directed spot values are compared as well.
// -----------------------------------------------------------------------------
module tb_watchdog_multi;

  localparam int NCH = 3;
  localparam logic [1:0] SETTO = 2'b00, SETWIN = 2'b01, KICK = 2'b10, CLEAR = 2'b11;

  logic        clk = 1'b0;
  logic        rst, tick, stb, we;
  logic [2:0]  addr;
  logic [31:0] data_in;
  logic [31:0] dout_a, dout_b;
  logic [2:0]  trig_a, trig_b;
  logic        any_a, any_b, ack_a, ack_b;

  always #5 clk = ~clk;

  watchdog_multi #(.NCH(NCH), .CW(16), .PRESC(1)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .stb(stb), .we(we), .addr(addr),
    .data_in(data_in), .data_out(dout_a), .trig(trig_a), .trig_any(any_a), .ack(ack_a)
  );

  watchdog_multi #(.NCH(NCH), .CW(8), .PRESC(4)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .stb(stb), .we(we), .addr(addr),
    .data_in(data_in), .data_out(dout_b), .trig(trig_b), .trig_any(any_b), .ack(ack_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model, index [d] = 0 for dut_a, 1 for dut_b
  // ---------------------------------------------------------------------------
  int m_to  [2][NCH];
  int m_win [2][NCH];
  int m_tk  [2][NCH];
  bit m_en  [2][NCH];
  bit m_wm  [2][NCH];
  bit m_ea  [2][NCH];
  bit m_la  [2][NCH];
  int m_pc  [2];

  function automatic int presc_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = 0;
      for (int c = 0; c < NCH; c++) begin
        m_to[d][c] = 0; m_win[d][c] = 0; m_tk[d][c] = 0;
        m_en[d][c] = 0; m_wm[d][c] = 0; m_ea[d][c] = 0; m_la[d][c] = 0;
      end
    end
  endfunction

  // Effect of one clock edge given the inputs present before that edge.
  function automatic void model_step(input int d);
    int         ch, val;
    logic [1:0] op;
    bit         ct;
    ch  = int'(addr[2:1]);
    op  = data_in[31:30];
    val = (d == 0) ? int'(data_in[15:0]) : int'(data_in[7:0]);
    ct  = tick && (m_pc[d] == presc_of(d) - 1);
    if (tick) m_pc[d] = ct ? 0 : m_pc[d] + 1;
    for (int c = 0; c < NCH; c++) begin
      if (stb && we && ch == c) begin
        case (op)
          SETTO:  begin m_to[d][c] = val; m_tk[d][c] = 0; m_ea[d][c] = 0;
                        m_la[d][c] = 0; m_en[d][c] = (val != 0); end
          SETWIN: begin m_win[d][c] = val; m_wm[d][c] = (val != 0); end
          KICK:   if (m_en[d][c]) begin
                    if (m_wm[d][c] && m_tk[d][c] < m_win[d][c]) begin
                      m_ea[d][c] = 1; m_en[d][c] = 0;
                    end else m_tk[d][c] = 0;
                  end
          default: begin m_ea[d][c] = 0; m_la[d][c] = 0; m_tk[d][c] = 0;
                         m_en[d][c] = (m_to[d][c] != 0); end
        endcase
      end else if (m_en[d][c]) begin
        if (m_tk[d][c] == m_to[d][c]) begin m_la[d][c] = 1; m_en[d][c] = 0; end
        else if (ct) m_tk[d][c]++;
      end
    end
  endfunction

  function automatic logic [2:0] m_trig(input int d);
    logic [2:0] t = '0;
    for (int c = 0; c < NCH; c++) t[c] = m_ea[d][c] | m_la[d][c];
    return t;
  endfunction

  function automatic logic [31:0] m_read(input int d);
    int ch;
    if (!(stb && !we)) return 32'h0;
    ch = int'(addr[2:1]);
    if (ch >= NCH) return 32'h0;
    if (addr[0])
      return (32'(m_win[d][ch]) << 16) | (32'(m_wm[d][ch]) << 3) |
             (32'(m_en[d][ch]) << 2) | (32'(m_ea[d][ch]) << 1) | 32'(m_la[d][ch]);
    return (32'(m_tk[d][ch]) << 16) | 32'(m_to[d][ch]);
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [2:0]  tr_a, tr_b;
    logic [31:0] rd_a, rd_b;
    logic        ack;
  } exp_t;

  exp_t sb_q[$];

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("trig_a",     32'(trig_a), 32'(e.tr_a));
        check("trig_b",     32'(trig_b), 32'(e.tr_b));
        check("trig_any_a", 32'(any_a),  32'(|e.tr_a));
        check("trig_any_b", 32'(any_b),  32'(|e.tr_b));
        check("data_out_a", dout_a,      e.rd_a);
        check("data_out_b", dout_b,      e.rd_b);
        check("ack",        32'({ack_a, ack_b}), 32'({e.ack, e.ack}));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  task automatic drive(input logic r, input logic t, input logic s, input logic w,
                       input logic [2:0] a, input logic [31:0] d);
    exp_t e;
    @(posedge clk);
    if (!rst) begin model_step(0); model_step(1); end
    #1;
    rst = r; tick = t; stb = s; we = w; addr = a; data_in = d;
    if (r) model_reset();
    e.tr_a = m_trig(0); e.tr_b = m_trig(1);
    e.rd_a = m_read(0); e.rd_b = m_read(1);
    e.ack  = s;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input logic t);
    drive(1'b0, t, 1'b0, 1'b0, 3'b000, 32'h0);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin cyc(1'b1); cyc(1'b0); end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] op, input int val);
    drive(1'b0, 1'b0, 1'b1, 1'b1, {ch, 1'b0}, {op, 30'(val)});
  endtask

  task automatic rd(input logic [1:0] ch, input logic f);
    drive(1'b0, 1'b0, 1'b1, 1'b0, {ch, f}, 32'h0);
  endtask

  // Directed value on the next falling edge. kind: 0 dout_a, 1 trig_a,
  // 2 trig_b, 3 dout_b, 4 trig_any_a
  task automatic spot(input string nm, input int kind, input logic [31:0] exp);
    @(negedge clk);
    case (kind)
      0:       check(nm, dout_a, exp);
      1:       check(nm, 32'(trig_a), exp);
      2:       check(nm, 32'(trig_b), exp);
      3:       check(nm, dout_b, exp);
      default: check(nm, 32'(any_a), exp);
    endcase
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    #2 rst = 1'b1;
    model_reset();
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    cyc(1'b0);

    // Reset state
    rd(2'd0, 1'b0); spot("reset_ticker_timeout", 0, 32'h0);
    rd(2'd0, 1'b1); spot("reset_status", 0, 32'h0);

    // T1: late timeout
    wr(2'd0, SETTO, 5);
    ticks(6);
    rd(2'd0, 1'b0); spot("t1_ticker_timeout", 0, 32'h0005_0005);
    rd(2'd0, 1'b1); spot("t1_status", 0, 32'h0000_0001);
    spot("t1_trig", 1, 32'h1);

    // T2: early kick, then a kick outside the window
    wr(2'd1, SETTO, 10);
    wr(2'd1, SETWIN, 4);
    ticks(2);
    wr(2'd1, KICK, 0);
    rd(2'd1, 1'b0); spot("t2_early_ticker", 0, 32'h0002_000A);
    rd(2'd1, 1'b1); spot("t2_early_status", 0, 32'h0004_000A);
    spot("t2_trig", 1, 32'h3);
    ticks(3);
    rd(2'd1, 1'b0); spot("t2_frozen_ticker", 0, 32'h0002_000A);
    wr(2'd1, SETTO, 10);
    ticks(6);
    wr(2'd1, KICK, 0);
    rd(2'd1, 1'b0); spot("t2_late_kick_ticker", 0, 32'h0000_000A);
    spot("t2_no_trig", 1, 32'h1);

    // T3: regular kicks keep channel 2 alive; stop and it fires; CLEAR re-arms
    wr(2'd1, SETTO, 0);
    wr(2'd2, SETTO, 5);
    repeat (17) begin ticks(3); wr(2'd2, KICK, 0); end
    spot("t3_kicked_no_trig", 1, 32'h1);
    ticks(6);
    spot("t3_trig", 1, 32'h5);
    wr(2'd2, CLEAR, 0);
    rd(2'd2, 1'b1); spot("t3_clear_status", 0, 32'h0000_0004);
    rd(2'd2, 1'b0); spot("t3_clear_ticker", 0, 32'h0000_0005);
    spot("t3_clear_trig", 1, 32'h1);

    // T4: SETTO on the match cycle wins; simultaneous timeouts
    wr(2'd2, SETTO, 0);
    wr(2'd0, SETTO, 3);
    ticks(2);
    cyc(1'b1);
    wr(2'd0, SETTO, 3);
    rd(2'd0, 1'b0); spot("t4_override_ticker", 0, 32'h0000_0003);
    spot("t4_override_no_trig", 1, 32'h0);
    wr(2'd0, SETTO, 4);
    wr(2'd1, SETTO, 4);
    ticks(6);
    spot("t4_both_trig", 1, 32'h3);
    spot("t4_trig_any", 4, 32'h1);

    // T6: asynchronous reset mid-count, then idle ticks
    wr(2'd0, SETTO, 100);
    ticks(5);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0);
    spot("t6_reset_trig_a", 1, 32'h0);
    spot("t6_reset_read", 0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    cyc(1'b0);
    ticks(20);
    spot("t6_after_reset_a", 1, 32'h0);
    spot("t6_after_reset_b", 2, 32'h0);

    // T5: prescaler of 4 on dut_b, out-of-range channel
    wr(2'd0, SETTO, 2);
    ticks(7);
    spot("t5_presc_not_yet", 2, 32'h0);
    ticks(5);
    spot("t5_presc_trig", 2, 32'h1);
    wr(2'd3, SETTO, 7);
    wr(2'd3, CLEAR, 0);
    rd(2'd3, 1'b0); spot("t5_oob_read_a", 0, 32'h0);
    rd(2'd3, 1'b1); spot("t5_oob_read_b", 3, 32'h0);
    rd(2'd0, 1'b0); spot("t5_ch0_untouched", 0, 32'h0002_0002);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic        r, t, s, w;
      logic [2:0]  a;
      logic [31:0] d;
      r = ($urandom_range(0, 299) == 0);
      t = $urandom_range(0, 1) == 1;
      s = ($urandom_range(0, 3) == 0);
      w = $urandom_range(0, 1) == 1;
      a = 3'($urandom_range(0, 7));
      d = {2'($urandom_range(0, 3)), 30'(($urandom_range(0, 5) == 0) ? $urandom
                                                                     : $urandom_range(0, 9))};
      drive(r, t, s, w, a, d);
    end
    cyc(1'b0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
